// File: rtl/booth_product_acc_if.sv
// Handshake/data bundle between the Booth multiplier side and the product
// accumulator: product input, start control and the result handshake.
interface booth_product_acc_if;
  logic        start;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic [63:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        ovf;
  logic        drop;
  logic [7:0]  cnt;

  modport master (
    output start, prod_in, prod_valid, acc_ready,
    input  acc_out, acc_valid, ovf, drop, cnt
  );

  modport slave (
    input  start, prod_in, prod_valid, acc_ready,
    output acc_out, acc_valid, ovf, drop, cnt
  );
endinterface

// File: rtl/booth_product_acc.sv
// Sums N signed 64-bit multiplier products (one per rising edge of the level
// valid) in a guarded accumulator and returns a saturated result over valid/ready.
module booth_product_acc #(
  parameter int N     = 4,
  parameter int GUARD = 8
) (
  input logic                CLK,
  input logic                reset,
  booth_product_acc_if.slave bus
);

  localparam int         W     = 64 + GUARD;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [7:0] N_CNT = 8'(N);

  // Clamp the wide sum into 64 bits; bit 64 of the result flags a clamp.
  function automatic logic [64:0] saturate(input logic signed [W-1:0] s);
    logic [64:0] r;
    if ((&s[W-1:63]) || (~|s[W-1:63])) begin
      r = {1'b0, s[63:0]};
    end else if (s[W-1]) begin
      r = {1'b1, 1'b1, {63{1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {63{1'b1}}};
    end
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [63:0]         acc_out_q, acc_out_d;
  logic                acc_valid_q, acc_valid_d;
  logic                ovf_q, ovf_d;
  logic                drop_q, drop_d;
  logic                prev_valid_q;

  logic                edge_s;
  logic signed [W-1:0] prod_ext_s;
  logic signed [W-1:0] sum_s;
  logic [64:0]         sat_s;
  logic [7:0]          cnt_inc_s;

  assign edge_s     = bus.prod_valid & ~prev_valid_q;
  assign prod_ext_s = W'($signed(bus.prod_in));
  assign sum_s      = acc_q + prod_ext_s;
  assign sat_s      = saturate(sum_s);
  assign cnt_inc_s  = cnt_q + 8'd1;

  // Next-state logic for the accumulate / present-result sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        // A start wins over a coincident product edge, which is then lost.
        if (bus.start) begin
          state_d = ACCUM;
          acc_d   = {W{1'b0}};
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
          drop_d  = edge_s;
        end else if (edge_s) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ACCUM: begin
        if (bus.start) begin
          acc_d  = {W{1'b0}};
          cnt_d  = 8'd0;
          ovf_d  = 1'b0;
          drop_d = edge_s;
        end else if (edge_s) begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == N_CNT) begin
            state_d     = DONE;
            acc_out_d   = sat_s[63:0];
            ovf_d       = sat_s[64];
            acc_valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        // Start is deliberately ignored here, even alongside the handshake.
        drop_d = drop_q | edge_s;
        if (acc_valid_q && bus.acc_ready) begin
          state_d     = IDLE;
          acc_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        acc_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; prev_valid resets high so a held valid is ignored.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= {W{1'b0}};
      cnt_q        <= 8'd0;
      acc_out_q    <= 64'd0;
      acc_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      prev_valid_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      acc_out_q    <= acc_out_d;
      acc_valid_q  <= acc_valid_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      prev_valid_q <= bus.prod_valid;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.drop      = drop_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_booth_product_acc.sv
// Directed bench for booth_product_acc: three instances (N=4, N=2, N=1)
// share the product stream; each has its own start and acc_ready.
module tb_booth_product_acc;

  logic        CLK;
  logic        reset;
  logic [63:0] prod_in_s;
  logic        prod_valid_s;
  logic [2:0]  start_s;
  logic [2:0]  ready_s;

  int checks = 0;
  int errors = 0;

  booth_product_acc_if if4 ();
  booth_product_acc_if if2 ();
  booth_product_acc_if if1 ();

  assign if4.start = start_s[0];
  assign if4.prod_in = prod_in_s;
  assign if4.prod_valid = prod_valid_s;
  assign if4.acc_ready = ready_s[0];
  assign if2.start = start_s[1];
  assign if2.prod_in = prod_in_s;
  assign if2.prod_valid = prod_valid_s;
  assign if2.acc_ready = ready_s[1];
  assign if1.start = start_s[2];
  assign if1.prod_in = prod_in_s;
  assign if1.prod_valid = prod_valid_s;
  assign if1.acc_ready = ready_s[2];

  booth_product_acc #(.N(4), .GUARD(8)) u4 (.CLK(CLK), .reset(reset), .bus(if4));
  booth_product_acc #(.N(2), .GUARD(8)) u2 (.CLK(CLK), .reset(reset), .bus(if2));
  booth_product_acc #(.N(1), .GUARD(8)) u1 (.CLK(CLK), .reset(reset), .bus(if1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One product edge: valid high for one cycle, then low for one cycle.
  task automatic pulse(input logic [63:0] v);
    prod_in_s    = v;
    prod_valid_s = 1'b1;
    tick();
    prod_valid_s = 1'b0;
    tick();
  endtask

  task automatic start_on(input int idx);
    start_s[idx] = 1'b1;
    tick();
    start_s[idx] = 1'b0;
  endtask

  task automatic handshake(input int idx);
    ready_s[idx] = 1'b1;
    tick();
    ready_s[idx] = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    prod_in_s    = 64'd0;
    prod_valid_s = 1'b1;
    start_s      = 3'b000;
    ready_s      = 3'b000;
    tick();
    tick();
    chk("rst_acc_out", if4.acc_out, 64'd0);
    chk("rst_acc_valid", {63'd0, if4.acc_valid}, 64'd0);
    chk("rst_ovf", {63'd0, if4.ovf}, 64'd0);
    chk("rst_drop", {63'd0, if4.drop}, 64'd0);
    chk("rst_cnt", {56'd0, if4.cnt}, 64'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("held_valid_no_edge", {63'd0, if4.drop}, 64'd0);
    prod_valid_s = 1'b0;
    tick();

    // N=4 cancelling products, with latency check on the 4th edge.
    start_on(0);
    pulse(64'd2700);
    pulse(-64'sd2700);
    pulse(-64'sd2700);
    chk("t1_cnt3", {56'd0, if4.cnt}, 64'd3);
    chk("t1_valid_before", {63'd0, if4.acc_valid}, 64'd0);
    prod_in_s    = 64'd2700;
    prod_valid_s = 1'b1;
    tick();
    chk("t1_valid_lat1", {63'd0, if4.acc_valid}, 64'd1);
    chk("t1_acc_out", if4.acc_out, 64'd0);
    chk("t1_ovf", {63'd0, if4.ovf}, 64'd0);
    chk("t1_cnt", {56'd0, if4.cnt}, 64'd4);
    chk("t1_drop", {63'd0, if4.drop}, 64'd0);
    prod_valid_s = 1'b0;
    tick();
    handshake(0);
    chk("t1_hs_valid", {63'd0, if4.acc_valid}, 64'd0);

    // Held level counts once.
    start_on(0);
    prod_in_s    = 64'd2700;
    prod_valid_s = 1'b1;
    repeat (30) tick();
    chk("t2_level_once", {56'd0, if4.cnt}, 64'd1);
    prod_valid_s = 1'b0;
    tick();
    pulse(64'd2700);
    pulse(64'd2700);
    pulse(64'd2700);
    chk("t2_acc_out", if4.acc_out, 64'd10800);
    chk("t2_valid", {63'd0, if4.acc_valid}, 64'd1);
    handshake(0);
    chk("t2_hs_valid", {63'd0, if4.acc_valid}, 64'd0);
    chk("t2_hold_out", if4.acc_out, 64'd10800);

    // N=2 positive and negative saturation.
    start_on(1);
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    pulse(64'h7FFF_FFFF_FFFF_FFFF);
    chk("t3_pos_sat", if2.acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t3_pos_ovf", {63'd0, if2.ovf}, 64'd1);
    handshake(1);
    chk("t3_ovf_hold_idle", {63'd0, if2.ovf}, 64'd1);
    start_on(1);
    chk("t3_ovf_clr", {63'd0, if2.ovf}, 64'd0);
    pulse(64'h8000_0000_0000_0000);
    pulse(64'h8000_0000_0000_0000);
    chk("t3_neg_sat", if2.acc_out, 64'h8000_0000_0000_0000);
    chk("t3_neg_ovf", {63'd0, if2.ovf}, 64'd1);
    handshake(1);

    // N=2 backpressure with an edge arriving while DONE.
    start_on(1);
    chk("t4_drop_clr", {63'd0, if2.drop}, 64'd0);
    pulse(-64'sd2700);
    pulse(64'd900);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) prod_valid_s = 1'b1;
      if (i == 4) prod_valid_s = 1'b0;
      tick();
      chk("t4_hold_out", if2.acc_out, -64'sd1800);
      chk("t4_hold_valid", {63'd0, if2.acc_valid}, 64'd1);
    end
    chk("t4_drop", {63'd0, if2.drop}, 64'd1);
    chk("t4_ovf", {63'd0, if2.ovf}, 64'd0);
    handshake(1);
    chk("t4_hs_valid", {63'd0, if2.acc_valid}, 64'd0);

    // Asynchronous reset mid-accumulation.
    start_on(0);
    pulse(64'd5);
    pulse(64'd6);
    chk("t5_cnt2", {56'd0, if4.cnt}, 64'd2);
    prod_valid_s = 1'b1;
    reset        = 1'b1;
    #1;
    chk("t5_async_out", if4.acc_out, 64'd0);
    chk("t5_async_cnt", {56'd0, if4.cnt}, 64'd0);
    chk("t5_async_valid", {63'd0, if4.acc_valid}, 64'd0);
    chk("t5_async_drop", {63'd0, if4.drop}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t5_no_accept", {63'd0, if4.drop}, 64'd0);
    prod_valid_s = 1'b0;
    tick();
    start_on(0);
    pulse(64'd1);
    pulse(64'd1);
    pulse(64'd1);
    pulse(64'd1);
    chk("t5_acc_out", if4.acc_out, 64'd4);
    handshake(0);

    // Start coincident with an edge in ACCUM: edge discarded, drop set.
    start_on(0);
    pulse(64'd10);
    start_s[0]   = 1'b1;
    prod_in_s    = 64'd100;
    prod_valid_s = 1'b1;
    tick();
    start_s[0]   = 1'b0;
    prod_valid_s = 1'b0;
    chk("t6_cnt0", {56'd0, if4.cnt}, 64'd0);
    chk("t6_drop", {63'd0, if4.drop}, 64'd1);
    tick();
    pulse(64'd1);
    pulse(64'd2);
    pulse(64'd3);
    pulse(64'd4);
    chk("t6_acc_out", if4.acc_out, 64'd10);
    chk("t6_cnt4", {56'd0, if4.cnt}, 64'd4);
    chk("t6_drop_sticky", {63'd0, if4.drop}, 64'd1);
    handshake(0);

    // N=1 pass-through, start ignored in DONE and alongside handshake.
    start_on(2);
    prod_in_s    = -64'sd7;
    prod_valid_s = 1'b1;
    tick();
    chk("t7_valid", {63'd0, if1.acc_valid}, 64'd1);
    chk("t7_out", if1.acc_out, -64'sd7);
    chk("t7_ovf", {63'd0, if1.ovf}, 64'd0);
    prod_valid_s = 1'b0;
    tick();
    start_on(2);
    chk("t7_start_ign_valid", {63'd0, if1.acc_valid}, 64'd1);
    chk("t7_start_ign_cnt", {56'd0, if1.cnt}, 64'd1);
    start_s[2] = 1'b1;
    ready_s[2] = 1'b1;
    tick();
    start_s[2] = 1'b0;
    ready_s[2] = 1'b0;
    chk("t7_hs_valid", {63'd0, if1.acc_valid}, 64'd0);
    tick();
    pulse(64'd55);
    chk("t7_idle_no_accept", {63'd0, if1.acc_valid}, 64'd0);
    chk("t7_idle_out_hold", if1.acc_out, -64'sd7);
    chk("t7_idle_drop", {63'd0, if1.drop}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
